// File: rtl/dot_matrix_scanner_pkg.sv
// Shared constants for the 16x16 dot-matrix row scanner.
// Build option: DOT_MATRIX_ACTIVE_LOW_EN selects inverted (common-anode)
// row/column drive. When it is undefined, drive is active-high.
package dot_matrix_scanner_pkg;

    // Matrix geometry
    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int ROW_W = 4;

    // FSM state encodings
    typedef logic [1:0] dm_state_t;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_SHOW  = 2'd3;

    // Pin level that leaves every LED dark. The output registers XOR their
    // active-high value with this, so one constant covers both polarities.
`ifdef DOT_MATRIX_ACTIVE_LOW_EN
    localparam logic [COLS-1:0] OUT_DARK = '1;
`else
    localparam logic [COLS-1:0] OUT_DARK = '0;
`endif

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves both BLANK and SHOW, so it is sized for the longer.
    function automatic int timer_width(input int clk_div, input int blank_cycles);
        return $clog2(max2(clk_div, blank_cycles) + 1);
    endfunction

endpackage

// File: rtl/dot_matrix_scanner_timer.sv
// Loadable down-counter used to time the BLANK and SHOW phases.
// load takes priority; done is high while the count is zero, i.e. during the
// final cycle of a phase loaded with (length - 1).
module dm_row_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Reload on strobe, otherwise count down and stick at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for a 16x16 LED dot-matrix. Walks row_bin through a
// combinational pattern ROM, latches the returned column word, then lights
// one row at a time with a dark gap before each row to avoid ghosting.
// Row period = BLANK_CYCLES + 1 + CLK_DIV clocks.
// Build option: DOT_MATRIX_ACTIVE_LOW_EN inverts row_out/col_out at the
// output registers for common-anode boards.
module dot_matrix_scanner
    import dot_matrix_scanner_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [ROW_W-1:0] row_bin,
    input  logic [COLS-1:0]  col_in,
    output logic [ROWS-1:0]  row_out,
    output logic [COLS-1:0]  col_out,
    output logic             frame_done
);

    localparam int TW = timer_width(CLK_DIV, BLANK_CYCLES);

    // Timer is loaded with (length - 1) so done marks the last cycle
    localparam logic [TW-1:0] SHOW_RELOAD  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] BLANK_RELOAD = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;

    // With no blanking the scan goes straight from SHOW/IDLE into LOAD
    localparam dm_state_t S_ROW_START = (BLANK_CYCLES > 0) ? S_BLANK : S_LOAD;

    dm_state_t          state_q,      state_d;
    logic [ROW_W-1:0]   row_bin_q,    row_bin_d;
    logic [COLS-1:0]    col_reg_q,    col_reg_d;
    logic [ROWS-1:0]    row_out_q,    row_out_d;
    logic [COLS-1:0]    col_out_q,    col_out_d;
    logic               frame_done_q, frame_done_d;

    logic               timer_load;
    logic [TW-1:0]      timer_val;
    logic               timer_done;
    logic               lit_d;
    logic [ROWS-1:0]    row_onehot_d;

    dm_row_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Scan sequencing: enable low overrides everything and parks at row 0
    always_comb begin
        state_d      = state_q;
        row_bin_d    = row_bin_q;
        col_reg_d    = col_reg_q;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d   = S_IDLE;
            row_bin_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ROW_START;
                end
                S_BLANK: begin
                    if (timer_done) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The only cycle in which the ROM word is captured
                    col_reg_d = col_in;
                    state_d   = S_SHOW;
                end
                S_SHOW: begin
                    if (timer_done) begin
                        state_d      = S_ROW_START;
                        row_bin_d    = row_bin_q + ROW_W'(1);
                        frame_done_d = (row_bin_q == ROW_W'(ROWS - 1));
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Every state change reloads the timer; entering IDLE clears it
    always_comb begin
        timer_load = (state_d != state_q);
        case (state_d)
            S_BLANK: timer_val = BLANK_RELOAD;
            S_SHOW:  timer_val = SHOW_RELOAD;
            default: timer_val = '0;
        endcase
    end

    // Row decoder for the row that will be lit next cycle
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_dec
            assign row_onehot_d[gi] = (row_bin_d == ROW_W'(gi));
        end
    endgenerate

    // Output values follow the next state so the pins are lit exactly in SHOW
    always_comb begin
        lit_d     = (state_d == S_SHOW);
        row_out_d = (lit_d ? row_onehot_d : '0) ^ OUT_DARK;
        col_out_d = (lit_d ? col_reg_d    : '0) ^ OUT_DARK;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_bin_q    <= '0;
            col_reg_q    <= '0;
            row_out_q    <= OUT_DARK;
            col_out_q    <= OUT_DARK;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_bin_q    <= row_bin_d;
            col_reg_q    <= col_reg_d;
            row_out_q    <= row_out_d;
            col_out_q    <= col_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_bin    = row_bin_q;
    assign row_out    = row_out_q;
    assign col_out    = col_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Bench for dot_matrix_scanner: one instance with CLK_DIV=4/BLANK_CYCLES=2,
// one with CLK_DIV=1/BLANK_CYCLES=0, both fed by a pattern1 ROM model.
// Honours DOT_MATRIX_ACTIVE_LOW_EN for the expected pin polarity.
module tb_dot_matrix_scanner;

`ifdef DOT_MATRIX_ACTIVE_LOW_EN
    localparam logic [15:0] DARK_EXP = 16'hFFFF;
`else
    localparam logic [15:0] DARK_EXP = 16'h0000;
`endif

    typedef struct {
        logic [15:0] row;
        logic [15:0] col;
        logic [3:0]  rb;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b, glitch;
    logic [3:0]  rb_a, rb_b;
    logic [15:0] ci_a, ci_b, ro_a, co_a, ro_b, co_b;
    logic        fd_a, fd_b;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // pattern1: rows 1..13 light column 4, rows 0/14/15 are blank
    function automatic logic [15:0] rom(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'd13) ? 16'h0010 : 16'h0000;
    endfunction

    assign ci_a = glitch ? 16'hFFFF : rom(rb_a);
    assign ci_b = rom(rb_b);

    dot_matrix_scanner #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .row_bin(rb_a),
        .col_in(ci_a), .row_out(ro_a), .col_out(co_a), .frame_done(fd_a)
    );

    dot_matrix_scanner #(.CLK_DIV(1), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .row_bin(rb_b),
        .col_in(ci_b), .row_out(ro_b), .col_out(co_b), .frame_done(fd_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int sel, input exp_t e);
        if (sel == 0) begin
            chk({tag, " row_out"},    ro_a,                  e.row);
            chk({tag, " col_out"},    co_a,                  e.col);
            chk({tag, " row_bin"},    {12'h0, rb_a},         {12'h0, e.rb});
            chk({tag, " frame_done"}, {15'h0, fd_a},         {15'h0, e.fd});
        end else begin
            chk({tag, " row_out"},    ro_b,                  e.row);
            chk({tag, " col_out"},    co_b,                  e.col);
            chk({tag, " row_bin"},    {12'h0, rb_b},         {12'h0, e.rb});
            chk({tag, " frame_done"}, {15'h0, fd_b},         {15'h0, e.fd});
        end
    endtask

    // Expected pins for cycle t after leaving IDLE: rows of 'period' cycles,
    // the first dark_n of them dark, frame_done one cycle after each 16 rows.
    task automatic run_seg(input int sel, input int period, input int dark_n,
                           input int t0, input int t1, input int g_lo, input int g_hi);
        exp_t e;
        int   row;
        bit   lit;
        for (int t = t0; t <= t1; t++) begin
            row   = (t / period) % 16;
            lit   = (t % period) >= dark_n;
            e.rb  = 4'(row);
            e.fd  = (t > 0) && (t % (16 * period) == 0);
            e.row = (lit ? (16'h0001 << row) : 16'h0000) ^ DARK_EXP;
            e.col = (lit ? rom(4'(row)) : 16'h0000) ^ DARK_EXP;
            sb.push_back(e);
        end
        for (int t = t0; t <= t1; t++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk_all($sformatf("%s t=%0d", (sel == 0) ? "A" : "B", t), sel, e);
            glitch = (sel == 0) && (t >= g_lo) && (t <= g_hi);
            $display("cycle sel=%0d t=%0d row_bin=%0d checked", sel, t, e.rb);
        end
    endtask

    task automatic run_dark(input int sel, input int n, input string tag);
        exp_t e;
        e.row = DARK_EXP;
        e.col = DARK_EXP;
        e.rb  = 4'd0;
        e.fd  = 1'b0;
        for (int i = 0; i < n; i++) sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk_all($sformatf("%s %0d", tag, i), sel, e);
            $display("dark sel=%0d %s cycle %0d checked", sel, tag, i);
        end
    endtask

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        en_a   = 1'b0;
        en_b   = 1'b0;
        glitch = 1'b0;

        // Reset, then idle with enable low: everything dark
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_dark(0, 2, "A reset/idle");
        run_dark(1, 2, "B reset/idle");

        // Full frame plus part of the next, col_in forced to FFFF during the
        // SHOW of row 3 in the second frame (after its LOAD at t=135)
        en_a = 1'b1;
        run_seg(0, 7, 3, 0, 165, 136, 140);

        // Drop enable during the SHOW of row 7
        en_a = 1'b0;
        run_dark(0, 3, "A enable-drop");

        // Re-enable: fresh frame from row 0, frame_done only after 16 rows
        en_a = 1'b1;
        run_seg(0, 7, 3, 0, 151, -1, -1);

        // Asynchronous reset mid-SHOW of row 5, checked before the next edge
        #2 rst_n = 1'b0;
        #1;
        e.row = DARK_EXP;
        e.col = DARK_EXP;
        e.rb  = 4'd0;
        e.fd  = 1'b0;
        sb.push_back(e);
        e = sb.pop_front();
        chk_all("A async-reset", 0, e);
        $display("async reset mid-SHOW checked");
        en_a = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero blanking, one-cycle SHOW: LOAD/SHOW alternation and wrap
        en_b = 1'b1;
        run_seg(1, 2, 1, 0, 34, -1, -1);
        en_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
